ch3_wave_seq: RTL and testbench

- Channel 3 playback sequencer: the reader side of the wave RAM interface.
- Produces the wave RAM byte address, nibble select (efar_q), fetch strobe (gase) and fetch-busy flag (buke) that the wave RAM block consumes.
- Takes back the selected 4-bit sample (wave_play_d), holds it, and applies the NR32 volume shift to produce the channel 3 DAC input.

---
 rtl/ch3_wave_seq_pkg.sv | 28 ++
 rtl/ch3_freq_counter.sv | 42 ++++
 rtl/ch3_wave_seq.sv | 118 +++++++++++
 tb/tb_ch3_wave_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch3_wave_seq_pkg.sv
// ---------------------------------------------------------------------------
// ch3_wave_seq_pkg
// Shared APU definitions: frequency register width, wave position width,
// the NR32 volume-code enum and the volume shift helper.
// ---------------------------------------------------------------------------
package ch3_wave_seq_pkg;

  localparam int FREQ_W     = 11;
  localparam int WAVE_POS_W = 5;   // 32 nibbles in the wave RAM

  typedef enum logic [1:0] {
    VOL_MUTE = 2'd0,
    VOL_100  = 2'd1,
    VOL_50   = 2'd2,
    VOL_25   = 2'd3
  } vol_e;

  // NR32 volume: a right shift of the 4-bit sample, or mute.
  function automatic logic [3:0] apply_vol(input logic [3:0] sample, input vol_e vol);
    case (vol)
      VOL_100: apply_vol = sample;
      VOL_50:  apply_vol = sample >> 1;
      VOL_25:  apply_vol = sample >> 2;
      default: apply_vol = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ch3_freq_counter.sv
// ---------------------------------------------------------------------------
// ch3_freq_counter
// Up-counting period counter shared by the tone/wave channels. Counts from a
// reload value up to all-ones; the enabled step at all-ones reloads and
// raises ovf for that cycle.
//   clk, rst_n  : clock, async active-low reset
//   load        : synchronous reload from reload_val (wins over en)
//   en          : count enable (one step per asserted clock)
//   reload_val  : frequency register value
//   ovf         : combinational overflow, high on the step that wraps
// ---------------------------------------------------------------------------
module ch3_freq_counter
  import ch3_wave_seq_pkg::*;
#(
  parameter int W = FREQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] reload_val,
  output logic         ovf
);

  logic [W-1:0] cnt;

  // A load on the same edge suppresses the overflow so no advance is seen.
  assign ovf = en && !load && (cnt == '1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_val;
    end else if (en) begin
      cnt <= (cnt == '1) ? reload_val : cnt + W'(1);
    end
  end

endmodule

// File: rtl/ch3_wave_seq.sv
// ---------------------------------------------------------------------------
// ch3_wave_seq
// Channel 3 playback sequencer (wave RAM reader side). Steps a 5-bit nibble
// position at the programmed rate, issues a fetch strobe per step, captures
// the returned nibble after FETCH_LAT clocks and applies NR32 volume.
//   amuk_4mhz      : APU clock
//   napu_reset     : async active-low reset
//   nr30_dac_en    : DAC enable; low stops the channel
//   nr32_vol       : volume code
//   nr3x_freq      : frequency register
//   ch3_trigger    : start/restart pulse
//   ch3_len_expire : stop pulse from the length counter
//   cpu_addr       : CPU wave RAM address, routed out while inactive
//   wave_play_d    : nibble returned by the wave RAM block
//   ch3_active     : channel running
//   wave_addr      : wave RAM byte address
//   efar_q         : nibble select (0 = high nibble, 1 = low nibble)
//   gase           : one-clock fetch strobe
//   buke           : fetch in progress
//   ch3_out        : volume-scaled sample
// ---------------------------------------------------------------------------
module ch3_wave_seq #(
  parameter int FETCH_LAT = 2,   // 1..3
  parameter int FREQ_W    = ch3_wave_seq_pkg::FREQ_W
) (
  input  logic              amuk_4mhz,
  input  logic              napu_reset,
  input  logic              nr30_dac_en,
  input  logic [1:0]        nr32_vol,
  input  logic [FREQ_W-1:0] nr3x_freq,
  input  logic              ch3_trigger,
  input  logic              ch3_len_expire,
  input  logic [3:0]        cpu_addr,
  input  logic [3:0]        wave_play_d,
  output logic              ch3_active,
  output logic [3:0]        wave_addr,
  output logic              efar_q,
  output logic              gase,
  output logic              buke,
  output logic [3:0]        ch3_out
);

  import ch3_wave_seq_pkg::*;

  localparam logic [1:0] FETCH_INIT = 2'(FETCH_LAT);

  logic                  tick;
  logic                  active;
  logic [WAVE_POS_W-1:0] pos;
  logic                  gase_q;
  logic [1:0]            fetch_cnt;    // clocks of fetch left, 0 = idle
  logic [3:0]            sample_buf;
  logic                  load;
  logic                  stop;
  logic                  cnt_en;
  logic                  ovf;

  assign load   = ch3_trigger && nr30_dac_en;
  assign stop   = !nr30_dac_en || ch3_len_expire;
  // The stopping edge does not count, so pos holds where the channel ended.
  assign cnt_en = active && tick && !stop;

  ch3_freq_counter #(.W(FREQ_W)) u_freq (
    .clk        (amuk_4mhz),
    .rst_n      (napu_reset),
    .load       (load),
    .en         (cnt_en),
    .reload_val (nr3x_freq),
    .ovf        (ovf)
  );

  // 2 MHz enable, free-running whether or not the channel plays.
  always_ff @(posedge amuk_4mhz or negedge napu_reset) begin
    if (!napu_reset) tick <= 1'b0;
    else             tick <= ~tick;
  end

  always_ff @(posedge amuk_4mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      active     <= 1'b0;
      pos        <= '0;
      gase_q     <= 1'b0;
      fetch_cnt  <= '0;
      sample_buf <= '0;
    end else begin
      gase_q <= 1'b0;
      if (!nr30_dac_en) begin
        active    <= 1'b0;
        fetch_cnt <= '0;
      end else if (ch3_trigger) begin
        // Trigger beats both an overflow and a length expiry on this edge;
        // any in-flight fetch is dropped without capturing.
        active    <= 1'b1;
        pos       <= '0;
        fetch_cnt <= '0;
      end else if (ch3_len_expire) begin
        active    <= 1'b0;
        fetch_cnt <= '0;
      end else if (ovf) begin
        // Restarting the pipe supersedes an older fetch still in flight.
        pos       <= pos + WAVE_POS_W'(1);
        gase_q    <= 1'b1;
        fetch_cnt <= FETCH_INIT;
      end else if (fetch_cnt != 2'd0) begin
        fetch_cnt <= fetch_cnt - 2'd1;
        if (fetch_cnt == 2'd1) sample_buf <= wave_play_d;
      end
    end
  end

  assign ch3_active = active;
  assign efar_q     = pos[0];
  assign wave_addr  = active ? pos[WAVE_POS_W-1:1] : cpu_addr;
  assign gase       = gase_q;
  assign buke       = (fetch_cnt != 2'd0);
  assign ch3_out    = active ? apply_vol(sample_buf, vol_e'(nr32_vol)) : 4'd0;

endmodule

// File: tb/tb_ch3_wave_seq.sv
// ---------------------------------------------------------------------------
// tb_ch3_wave_seq
// Self-checking bench for ch3_wave_seq: directed sequences, a volume table,
// and randomized play against a behavioural model (ticks-to-next-step count,
// fetch age, captured sample).
// ---------------------------------------------------------------------------
module tb_ch3_wave_seq;

  localparam int FETCH_LAT = 2;
  localparam int FREQ_W    = 11;

  logic              amuk_4mhz      = 1'b0;
  logic              napu_reset     = 1'b0;
  logic              nr30_dac_en    = 1'b0;
  logic [1:0]        nr32_vol       = 2'd0;
  logic [FREQ_W-1:0] nr3x_freq      = '0;
  logic              ch3_trigger    = 1'b0;
  logic              ch3_len_expire = 1'b0;
  logic [3:0]        cpu_addr       = 4'd0;
  logic [3:0]        wave_play_d;
  logic              ch3_active;
  logic [3:0]        wave_addr;
  logic              efar_q;
  logic              gase;
  logic              buke;
  logic [3:0]        ch3_out;

  logic [7:0] ram [16];

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_active;
  int m_pos;
  int m_ticks_left;  // 2 MHz ticks until the next position step
  int m_fetch;       // clocks left in the pending fetch, 0 = none
  bit m_gase;
  int m_sbuf;
  int m_cyc;         // clocks since reset release

  ch3_wave_seq #(.FETCH_LAT(FETCH_LAT), .FREQ_W(FREQ_W)) dut (
    .amuk_4mhz      (amuk_4mhz),
    .napu_reset     (napu_reset),
    .nr30_dac_en    (nr30_dac_en),
    .nr32_vol       (nr32_vol),
    .nr3x_freq      (nr3x_freq),
    .ch3_trigger    (ch3_trigger),
    .ch3_len_expire (ch3_len_expire),
    .cpu_addr       (cpu_addr),
    .wave_play_d    (wave_play_d),
    .ch3_active     (ch3_active),
    .wave_addr      (wave_addr),
    .efar_q         (efar_q),
    .gase           (gase),
    .buke           (buke),
    .ch3_out        (ch3_out)
  );

  always #5 amuk_4mhz = ~amuk_4mhz;

  // Wave RAM model: byte at wave_addr, high nibble first.
  assign wave_play_d = efar_q ? ram[wave_addr][3:0] : ram[wave_addr][7:4];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int nib(input int p);
    logic [7:0] b;
    b = ram[p / 2];
    return (p % 2 == 1) ? int'(b[3:0]) : int'(b[7:4]);
  endfunction

  function automatic int scaled(input int s, input int vol);
    case (vol)
      1:       return s;
      2:       return s / 2;
      3:       return s / 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 0; m_pos = 0; m_ticks_left = 0; m_fetch = 0;
    m_gase = 0; m_sbuf = 0; m_cyc = 0;
  endtask

  // One clock of the model, using the inputs as they stand before the edge.
  task automatic model_edge();
    bit tick_now;
    bit adv;
    tick_now = (m_cyc % 2 == 1);
    adv = 0;
    m_gase = 0;
    if (!nr30_dac_en) begin
      m_active = 0; m_fetch = 0;
    end else if (ch3_trigger) begin
      m_active = 1; m_pos = 0; m_ticks_left = 2048 - int'(nr3x_freq); m_fetch = 0;
    end else if (ch3_len_expire) begin
      m_active = 0; m_fetch = 0;
    end else begin
      if (m_active && tick_now) begin
        m_ticks_left--;
        if (m_ticks_left == 0) begin
          adv = 1;
          m_pos = (m_pos + 1) % 32;
          m_ticks_left = 2048 - int'(nr3x_freq);
          m_gase = 1;
          m_fetch = FETCH_LAT;
        end
      end
      if (!adv && m_fetch > 0) begin
        if (m_fetch == 1) m_sbuf = nib(m_pos);
        m_fetch--;
      end
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    check("active", ch3_active, m_active);
    check("wave_addr", wave_addr, m_active ? m_pos / 2 : int'(cpu_addr));
    check("efar_q", efar_q, m_pos % 2);
    check("gase", gase, m_gase);
    check("buke", buke, m_fetch > 0);
    check("ch3_out", ch3_out, m_active ? scaled(m_sbuf, int'(nr32_vol)) : 0);
  endtask

  task automatic step();
    model_edge();
    @(posedge amuk_4mhz);
    #1;
    ch3_trigger = 1'b0;
    ch3_len_expire = 1'b0;
    compare_all();
  endtask

  task automatic wait_gase(input int budget);
    int n;
    n = 0;
    step();
    while (gase !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("wait_gase", gase, 1);
  endtask

  task automatic do_reset();
    napu_reset = 1'b0;
    ch3_trigger = 1'b0;
    ch3_len_expire = 1'b0;
    model_reset();
    repeat (2) @(posedge amuk_4mhz);
    @(negedge amuk_4mhz);
    napu_reset = 1'b1;
  endtask

  typedef struct {
    logic [1:0] vol;
    logic [3:0] exp_out;
  } vol_vec_t;

  typedef struct {
    int exp_addr;
    int exp_efar;
  } adv_vec_t;

  initial begin
    vol_vec_t vv [4];
    adv_vec_t av [3];
    int g;
    int last;
    int found;

    vv[0] = '{2'd0, 4'h0};
    vv[1] = '{2'd1, 4'hF};
    vv[2] = '{2'd2, 4'h7};
    vv[3] = '{2'd3, 4'h3};
    av[0] = '{0, 1};
    av[1] = '{1, 0};
    av[2] = '{1, 1};

    // Reset state: inactive, CPU address passes through
    cpu_addr = 4'hA;
    for (int k = 0; k < 16; k++) ram[k] = {4'(2 * k), 4'(2 * k + 1)};
    do_reset();
    check("rst_wave_addr", wave_addr, 4'hA);
    check("rst_ch3_out", ch3_out, 0);
    check("rst_gase", gase, 0);
    check("rst_buke", buke, 0);
    check("rst_active", ch3_active, 0);

    // First play: trigger on a tick-high edge, first step 4 clocks later
    nr30_dac_en = 1'b1;
    nr3x_freq = 11'h7FE;
    nr32_vol = 2'd1;
    cpu_addr = 4'h0;
    step();
    ch3_trigger = 1'b1;
    step();
    check("trig_active", ch3_active, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("first_adv_gase", gase, i == 4);
    end
    check("first_adv_efar", efar_q, 1);
    check("first_adv_addr", wave_addr, 0);
    repeat (FETCH_LAT) step();
    check("first_capture", ch3_out, 1);
    for (int i = 1; i < 3; i++) begin
      wait_gase(8);
      check("adv_addr", wave_addr, av[i].exp_addr);
      check("adv_efar", efar_q, av[i].exp_efar);
    end

    // 32 steps at the fastest rate: wrap to position 0, fetch never idle
    nr3x_freq = 11'h7FF;
    ch3_trigger = 1'b1;
    step();
    g = 0;
    last = -1;
    for (int i = 0; i < 80 && g < 32; i++) begin
      step();
      if (g > 0) check("wrap_buke", buke, 1);
      if (gase) begin
        if (g > 0) check("wrap_gase_spacing", i - last, 2);
        g++;
        last = i;
      end
    end
    check("wrap_advances", g, 32);
    check("wrap_addr", wave_addr, 0);
    check("wrap_efar", efar_q, 0);

    // Volume sweep on a full-scale sample
    for (int k = 0; k < 16; k++) ram[k] = 8'hFF;
    nr3x_freq = 11'h7FE;
    ch3_trigger = 1'b1;
    step();
    wait_gase(8);
    repeat (FETCH_LAT) step();
    for (int i = 0; i < 4; i++) begin
      nr32_vol = vv[i].vol;
      #1;
      check("vol_sweep", ch3_out, vv[i].exp_out);
    end
    nr32_vol = 2'd1;

    // Trigger on the same edge as an overflow
    nr3x_freq = 11'h7FF;
    repeat (6) step();
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (m_active && (m_cyc % 2 == 1) && m_ticks_left == 1) found = 1;
      else step();
    end
    check("ovf_edge_found", found, 1);
    ch3_trigger = 1'b1;
    step();
    check("trig_ovf_gase", gase, 0);
    check("trig_ovf_addr", wave_addr, 0);
    check("trig_ovf_efar", efar_q, 0);
    check("trig_ovf_active", ch3_active, 1);

    // DAC off in the middle of a fetch: no capture
    for (int k = 0; k < 16; k++) ram[k] = {4'(2 * k), 4'(2 * k + 1)};
    nr3x_freq = 11'h7FE;
    ch3_trigger = 1'b1;
    step();
    wait_gase(8);
    repeat (FETCH_LAT) step();
    wait_gase(8);
    nr30_dac_en = 1'b0;
    step();
    check("dac_off_active", ch3_active, 0);
    check("dac_off_out", ch3_out, 0);
    check("dac_off_buke", buke, 0);
    nr30_dac_en = 1'b1;
    ch3_trigger = 1'b1;
    step();
    check("dac_off_kept_sample", ch3_out, 1);

    // Length expiry mid-play, then retrigger shows the held sample
    wait_gase(8);
    repeat (FETCH_LAT) step();
    wait_gase(8);
    repeat (FETCH_LAT) step();
    cpu_addr = 4'h5;
    ch3_len_expire = 1'b1;
    step();
    check("len_active", ch3_active, 0);
    check("len_cpu_addr", wave_addr, 4'h5);
    ch3_trigger = 1'b1;
    step();
    check("retrig_addr", wave_addr, 0);
    check("retrig_efar", efar_q, 0);
    check("retrig_held_sample", ch3_out, 2);

    // Reset asserted in the middle of a fetch
    wait_gase(8);
    #2;
    napu_reset = 1'b0;
    #1;
    check("rst_mid_gase", gase, 0);
    check("rst_mid_buke", buke, 0);
    check("rst_mid_active", ch3_active, 0);
    check("rst_mid_addr", wave_addr, cpu_addr);
    do_reset();

    // Randomized play against the model
    for (int k = 0; k < 16; k++) ram[k] = 8'($urandom);
    nr30_dac_en = 1'b1;
    nr3x_freq = 11'h7F8;
    for (int i = 0; i < 3000; i++) begin
      nr30_dac_en = ($urandom_range(0, 99) != 0);
      ch3_trigger = ($urandom_range(0, 99) < 2);
      ch3_len_expire = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) nr32_vol = 2'($urandom);
      if ($urandom_range(0, 49) == 0) nr3x_freq = 11'h7F0 + 11'($urandom_range(0, 15));
      cpu_addr = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
